// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer handshake bundle for fifo_sync_flags: write side, read side,
// status flags and sticky errors. The FIFO takes the slave modport.
interface fifo_sync_flags_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_W:0]       count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost flags, sticky errors and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_sync_flags_if.slave  bus
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] CNT_AF    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] CNT_AE    = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  if (FIFO_DEPTH < 4 || (1 << ADDR_W) != FIFO_DEPTH) begin : g_bad_depth
    $error("fifo_sync_flags: FIFO_DEPTH must be a power of two >= 4");
  end
  if (AF_THRESH < 0 || AF_THRESH > FIFO_DEPTH ||
      AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH) begin : g_bad_thresh
    $error("fifo_sync_flags: AF_THRESH/AE_THRESH must lie in 0..FIFO_DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W:0]       wr_ptr, rd_ptr, count_q;
  logic                  overflow_q, underflow_q;
  logic                  full_w, empty_w, wr_acc, rd_acc;

  // The wrap bit distinguishes full from empty when the index bits coincide.
  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign wr_acc  = bus.wr_en && !full_w  && !bus.flush;
  assign rd_acc  = bus.rd_en && !empty_w && !bus.flush;

  // NOTE: storage is deliberately left out of reset; only pointers define contents,
  // which keeps the array mappable onto plain RAM without a reset port.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CNT_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + CNT_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (bus.wr_en && full_w)  overflow_q  <= 1'b1;
      if (bus.rd_en && empty_w) underflow_q <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is always presented; rd_en simply pops it.
  assign bus.data_out = mem[rd_ptr[ADDR_W-1:0]];
  assign bus.rd_valid = !empty_w;
`else
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) data_out_q <= mem[rd_ptr[ADDR_W-1:0]];
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= CNT_AF);
  assign bus.almost_empty = (count_q <= CNT_AE);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  logic unused_depth;
  assign unused_depth = ^CNT_DEPTH;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench for fifo_sync_flags: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fifo_sync_flags;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fifo_sync_flags_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  fifo_sync_flags #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents as a queue, plus the observable registered state.
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout = '0;
  logic          m_rdv  = 1'b0;
  logic          m_ovf  = 1'b0;
  logic          m_udf  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    int sz;
    sz = q.size();
    check({ctx, ".count"},        64'(bus.count),        64'(sz));
    check({ctx, ".empty"},        64'(bus.empty),        64'(sz == 0));
    check({ctx, ".full"},         64'(bus.full),         64'(sz == DEPTH));
    check({ctx, ".almost_full"},  64'(bus.almost_full),  64'(sz >= DEPTH - 2));
    check({ctx, ".almost_empty"}, 64'(bus.almost_empty), 64'(sz <= 2));
    check({ctx, ".overflow"},     64'(bus.overflow),     64'(m_ovf));
    check({ctx, ".underflow"},    64'(bus.underflow),    64'(m_udf));
`ifdef FIFO_FWFT_EN
    check({ctx, ".rd_valid"},     64'(bus.rd_valid),     64'(sz != 0));
    if (sz != 0) check({ctx, ".data_out"}, 64'(bus.data_out), 64'(q[0]));
`else
    check({ctx, ".rd_valid"},     64'(bus.rd_valid),     64'(m_rdv));
    check({ctx, ".data_out"},     64'(bus.data_out),     64'(m_dout));
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_rdv  = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // One clock: drive requests, advance the model by the FIFO rules, check #1 after the edge.
  task automatic step(input logic wr, input logic [DW-1:0] din, input logic rd,
                      input logic fl, input string ctx);
    bit was_full, was_empty;
    bus.wr_en   = wr;
    bus.data_in = din;
    bus.rd_en   = rd;
    bus.flush   = fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rdv = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (wr && was_full)  m_ovf = 1'b1;
      if (rd && was_empty) m_udf = 1'b1;
      m_rdv = rd && !was_empty;
      if (m_rdv) m_dout = q.pop_front();
      if (wr && !was_full) q.push_back(din);
    end
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.flush = 1'b0;
    check_all(ctx);
  endtask

  initial begin
    int wr_pct;
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;
    model_reset();

    // Reset state
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset");

    // Three writes then three reads, one-cycle read latency
    step(1'b1, 32'h11, 1'b0, 1'b0, "t1_wr");
    step(1'b1, 32'h22, 1'b0, 1'b0, "t1_wr");
    step(1'b1, 32'h33, 1'b0, 1'b0, "t1_wr");
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, "t1_rd");
    step(1'b0, '0, 1'b0, 1'b0, "t1_idle");

    // Fill to full, then an extra write is dropped and overflow sticks
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, 1'b0, "t2_fill");
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, "t2_over");

    // Full with read+write: read only; then both accepted, streaming 40 words through wrap
    step(1'b1, 32'hBAD0_0001, 1'b1, 1'b0, "t3_full_rw");
    for (int i = 0; i < 40; i++) step(1'b1, $urandom, 1'b1, 1'b0, "t3_stream");
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0, "t3_drain");
    step(1'b0, '0, 1'b0, 1'b1, "t3_flush");

    // Read while empty sets underflow, data_out holds; flush clears it
    step(1'b0, '0, 1'b1, 1'b0, "t4_under");
    step(1'b1, 32'h5A5A_5A5A, 1'b1, 1'b0, "t4_empty_rw");
    step(1'b0, '0, 1'b1, 1'b0, "t4_rd");
    step(1'b0, '0, 1'b0, 1'b1, "t4_flush");

    // Flush wins over a simultaneous write
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, "t5_wr");
    step(1'b1, 32'hFFFF_0000, 1'b1, 1'b1, "t5_flush_wr");

    // Single word: shown immediately in FWFT builds, one read empties it
    step(1'b1, 32'hAB, 1'b0, 1'b0, "t6_wr");
    step(1'b0, '0, 1'b0, 1'b0, "t6_idle");
    step(1'b0, '0, 1'b1, 1'b0, "t6_rd");

    // Random traffic with shifting write bias and occasional flush
    wr_pct = 80;
    for (int c = 0; c < 900; c++) begin
      if (c % 100 == 0) wr_pct = (c / 100 % 3 == 0) ? 80 : (c / 100 % 3 == 1) ? 20 : 50;
      step(($urandom_range(99) < wr_pct), $urandom, ($urandom_range(99) >= wr_pct - 10),
           ($urandom_range(63) == 0), "rand");
      if (c == 450) begin
        // Asynchronous reset away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
